// File: rtl/mem_responder_pkg.sv
// Shared constants and request decoding for the memory responder.
// Widths here are the defaults that the interface and top-level parameters start from.
package mem_responder_pkg;

  localparam int WORD_W      = 16;
  localparam int CPU_ADDR_W  = 16;
  localparam int MEM_LAT_MAX = 8;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_t;

  function automatic req_kind_t decode_req(input logic enable, input logic wr);
    if (!enable) return REQ_IDLE;
    return wr ? REQ_WRITE : REQ_READ;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory request/response bundle shared by requester and responder.
// Handshake: no ready; every non-reset edge with enable=1 accepts one request,
// and data_valid is a one-cycle strobe marking a read return on data_out.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = CPU_ADDR_W
) ();

  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [3:0]        outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, outstanding
  );

endinterface

// File: rtl/mem_responder_lat_pipe.sv
// Fixed-latency read return pipe: LATENCY stages of {valid, data} and a holding output register.
// ret_o flags that the oldest read returns at the coming edge.
module mem_lat_pipe #(
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_valid_o,
  output logic              ret_o
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dout_q;
  logic               dv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      dv_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      dv_q <= vld_q[LATENCY-1];
      if (vld_q[LATENCY-1]) begin
        dout_q <= dat_q[LATENCY-1];
      end
    end
  end

  // Payload needs no reset: it is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    dat_q[0] <= in_data_i;
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign data_out_o   = dout_q;
  assign data_valid_o = dv_q;
  assign ret_o        = vld_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: word storage, write port, read issue into the latency pipe,
// and the count of reads in flight.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W     = WORD_W,
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  req_kind_t             req;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ret;
  logic [3:0]            out_q;
  logic [3:0]            out_d;
  logic                  unused_addr;

  // Bit 0 selects a byte within the word; bits above the index wrap.
  assign idx         = bus.addr[DEPTH_LOG2:1];
  assign unused_addr = ^bus.addr;

  assign req    = decode_req(bus.enable, bus.wr);
  assign rd_acc = !rst && (req == REQ_READ);
  assign wr_acc = !rst && (req == REQ_WRITE);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[idx] <= bus.data_in;
    end
  end

  mem_lat_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (rd_acc),
    .in_data_i    (mem_q[idx]),
    .data_out_o   (bus.data_out),
    .data_valid_o (bus.data_valid),
    .ret_o        (ret)
  );

  always_comb begin
    out_d = out_q;
    if (rd_acc && !ret) begin
      out_d = out_q + 4'd1;
    end else if (!rd_acc && ret) begin
      out_d = out_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.outstanding = out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table for the LATENCY=4 build plus
// hand sequences for reset behaviour and a LATENCY=1 build.
module tb_mem_responder;

  logic clk;
  logic rst;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.LATENCY(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mem_responder #(.LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        exp_dv;
    logic [15:0] exp_dout;
    logic [3:0]  exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic void push(input logic en, input logic wr, input logic [15:0] addr,
                               input logic [15:0] din, input logic exp_dv,
                               input logic [15:0] exp_dout, input logic [3:0] exp_out);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = addr; v.din = din;
    v.exp_dv = exp_dv; v.exp_dout = exp_dout; v.exp_out = exp_out;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive0(input logic en, input logic wr, input logic [15:0] addr,
                        input logic [15:0] din);
    bus0.enable = en; bus0.wr = wr; bus0.addr = addr; bus0.data_in = din;
  endtask

  task automatic drive1(input logic en, input logic wr, input logic [15:0] addr,
                        input logic [15:0] din);
    bus1.enable = en; bus1.wr = wr; bus1.addr = addr; bus1.data_in = din;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect0(input string tag, input logic dv, input logic [15:0] dout,
                         input logic [3:0] outs);
    check({tag, ".dv"},   {15'd0, bus0.data_valid}, {15'd0, dv});
    check({tag, ".dout"}, bus0.data_out, dout);
    check({tag, ".out"},  {12'd0, bus0.outstanding}, {12'd0, outs});
  endtask

  task automatic expect1(input string tag, input logic dv, input logic [15:0] dout,
                         input logic [3:0] outs);
    check({tag, ".dv"},   {15'd0, bus1.data_valid}, {15'd0, dv});
    check({tag, ".dout"}, bus1.data_out, dout);
    check({tag, ".out"},  {12'd0, bus1.outstanding}, {12'd0, outs});
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b1, 1'b0, 16'h0010, 16'h0000);
    drive1(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Reset held 3 cycles with a read presented: nothing accepted, outputs zero.
    for (int i = 0; i < 3; i++) begin
      step();
      expect0($sformatf("rst%0d", i), 1'b0, 16'h0000, 4'd0);
      expect1($sformatf("rst1_%0d", i), 1'b0, 16'h0000, 4'd0);
    end
    rst = 1'b0;
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive1(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step();
      expect0($sformatf("post_rst%0d", i), 1'b0, 16'h0000, 4'd0);
    end

    // Write then read, return 4 edges after the read edge.
    push(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 4'd0);
    push(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 4'd1);
    push(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd1);
    push(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd1);
    push(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd1);
    push(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 4'd0);
    push(0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 4'd0);

    // Preload words 0..7 with 0xA000+i.
    for (int i = 0; i < 8; i++) begin
      push(1, 1, 16'(2 * i), 16'hA000 + 16'(i), 0, 16'hBEEF, 4'd0);
    end
    // Eight back-to-back reads; read k returns at edge k+4.
    for (int i = 0; i < 13; i++) begin
      int acc;
      int rets;
      logic dv;
      logic [15:0] dout;
      acc  = (i + 1 < 8) ? i + 1 : 8;
      rets = (i < 4) ? 0 : ((i - 3 < 8) ? i - 3 : 8);
      dv   = (i >= 4) && (i < 12);
      dout = dv ? 16'hA000 + 16'(i - 4) : ((i < 4) ? 16'hBEEF : 16'hA007);
      push(i < 8, 0, 16'(2 * i), 16'h0000, dv, dout, 4'(acc - rets));
    end

    // Aliasing: odd address and its even neighbour hit the same word.
    push(1, 1, 16'h0003, 16'h1234, 0, 16'hA007, 4'd0);
    push(1, 0, 16'h0002, 16'h0000, 0, 16'hA007, 4'd1);
    push(1, 0, 16'h0002, 16'h0000, 0, 16'hA007, 4'd2);
    push(1, 0, 16'h0003, 16'h0000, 0, 16'hA007, 4'd3);
    push(0, 0, 16'h0000, 16'h0000, 0, 16'hA007, 4'd3);
    push(0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 4'd2);
    push(0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 4'd1);
    push(0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 4'd0);
    push(0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 4'd0);

    foreach (vecs[k]) begin
      drive0(vecs[k].en, vecs[k].wr, vecs[k].addr, vecs[k].din);
      step();
      expect0($sformatf("vec%0d", k), vecs[k].exp_dv, vecs[k].exp_dout, vecs[k].exp_out);
    end

    // Reset mid-flight: two reads in the pipe, a write presented during reset is dropped.
    drive0(1, 1, 16'h0040, 16'h7777);
    step();
    expect0("mid_wr", 1'b0, 16'h1234, 4'd0);
    drive0(1, 0, 16'h0040, 16'h0000);
    step();
    expect0("mid_e0", 1'b0, 16'h1234, 4'd1);
    drive0(1, 0, 16'h0002, 16'h0000);
    step();
    expect0("mid_e1", 1'b0, 16'h1234, 4'd2);
    rst = 1'b1;
    drive0(1, 1, 16'h0040, 16'hDEAD);
    step();
    expect0("mid_rst", 1'b0, 16'h0000, 4'd0);
    rst = 1'b0;
    drive0(0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step();
      expect0($sformatf("mid_quiet%0d", i), 1'b0, 16'h0000, 4'd0);
    end
    drive0(1, 0, 16'h0040, 16'h0000);
    step();
    expect0("mid_rd", 1'b0, 16'h0000, 4'd1);
    drive0(0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      expect0($sformatf("mid_wait%0d", i), 1'b0, 16'h0000, 4'd1);
    end
    step();
    expect0("mid_ret", 1'b1, 16'h7777, 4'd0);

    // LATENCY=1 build: registered read, then alternating write/read.
    drive1(1, 1, 16'h0020, 16'h5A5A);
    step();
    expect1("l1_wr", 1'b0, 16'h0000, 4'd0);
    drive1(1, 0, 16'h0020, 16'h0000);
    step();
    expect1("l1_rd", 1'b0, 16'h0000, 4'd1);
    drive1(0, 0, 16'h0000, 16'h0000);
    step();
    expect1("l1_ret", 1'b1, 16'h5A5A, 4'd0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] prev;
      prev = (k == 0) ? 16'h5A5A : 16'h1100 + 16'(k - 1);
      drive1(1, 1, 16'h0030 + 16'(2 * k), 16'h1100 + 16'(k));
      step();
      expect1($sformatf("l1_alt_w%0d", k), k > 0, prev, 4'd0);
      drive1(1, 0, 16'h0030 + 16'(2 * k), 16'h0000);
      step();
      expect1($sformatf("l1_alt_r%0d", k), 1'b0, prev, 4'd1);
    end
    drive1(0, 0, 16'h0000, 16'h0000);
    step();
    expect1("l1_alt_last", 1'b1, 16'h1103, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
